cc_poscomparator_scan: RTL and testbench
========================================

CC_POSCOMPARATOR_SCAN -- requirements
Module: cc_poscomparator_scan

Interface
REQ-001 Parameters SHALL be: PosCOMPARATOR_DATAWIDTH, default 8, row/position word width; FIELD_LSB, default 4, lowest compared bit; FIELD_WIDTH, default 4, number of compared bits; NUM_ROWS, default 8, rows scanned per request; ROWIDX_WIDTH, default 3, row index width.
REQ-002 Parameter legality SHALL be: FIELD_LSB+FIELD_WIDTH <= PosCOMPARATOR_DATAWIDTH; FIELD_WIDTH >= 1; 1 <= NUM_ROWS <= 2^ROWIDX_WIDTH.
REQ-003 CC_POSCOMPARATOR_SCAN_CLOCK_50  in  1  single clock; all state changes on its rising edge.
REQ-004 CC_POSCOMPARATOR_SCAN_RESET_InHigh  in  1  synchronous, active-high reset.
REQ-005 CC_POSCOMPARATOR_SCAN_start  in  1  scan request, sampled only in IDLE.
REQ-006 CC_POSCOMPARATOR_SCAN_mode  in  1  0 = complement match, 1 = overlap match; captured with start.
REQ-007 CC_POSCOMPARATOR_SCAN_posjug  in  DATAWIDTH  player position word; captured with start.
REQ-008 CC_POSCOMPARATOR_SCAN_rowaddr  out  ROWIDX_WIDTH  row read address to board memory.
REQ-009 CC_POSCOMPARATOR_SCAN_rowdata  in  DATAWIDTH  row word; valid one cycle after its address is driven (synchronous-read memory).
REQ-010 CC_POSCOMPARATOR_SCAN_busy  out  1  high in SCAN and DRAIN.
REQ-011 CC_POSCOMPARATOR_SCAN_done  out  1  one-cycle completion pulse.
REQ-012 CC_POSCOMPARATOR_SCAN_hit  out  1  at least one row matched in the last completed scan.
REQ-013 CC_POSCOMPARATOR_SCAN_firsthit  out  ROWIDX_WIDTH  lowest matching row index of last completed scan.
REQ-014 CC_POSCOMPARATOR_SCAN_hitcount  out  ROWIDX_WIDTH+1  number of matching rows in last completed scan.

Function
REQ-015 Field F(x) SHALL be x[FIELD_LSB+FIELD_WIDTH-1 : FIELD_LSB].
REQ-016 Mode 0 match SHALL be: every bit of F(row) differs from the same bit of F(pos), i.e. F(row) == ~F(pos).
REQ-017 Mode 1 match SHALL be: (F(row) AND F(pos)) != 0.
REQ-018 FSM states SHALL be IDLE, SCAN, DRAIN, DONE; all outputs registered.
REQ-019 IDLE: start=1 captures posjug and mode, clears internal accumulators, goes to SCAN with rowaddr=0; start=0 stays in IDLE; rowaddr held at 0.
REQ-020 SCAN: rowaddr increments by 1 per cycle from 0 to NUM_ROWS-1; the cycle after rowaddr=NUM_ROWS-1 enters DRAIN.
REQ-021 From the second SCAN cycle through DRAIN, rowdata SHALL be compared against the address driven in the previous cycle; exactly NUM_ROWS compares per scan.
REQ-022 On each match, hit count SHALL increment; the first match index SHALL be recorded and never overwritten by later matches in the same scan.
REQ-023 DRAIN SHALL go to DONE unconditionally; on that transition hit, firsthit and hitcount SHALL be loaded from the accumulators.
REQ-024 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-025 Latency: done SHALL be high exactly NUM_ROWS+2 cycles after the edge that sampled start.
REQ-026 hit, firsthit, hitcount SHALL hold their values until the next DONE or reset.
REQ-027 No match: hit=0, firsthit=0, hitcount=0.
REQ-028 start while busy or in DONE SHALL be ignored, not queued; changes on posjug or mode during a scan SHALL not affect it.
REQ-029 All rows matching SHALL give hitcount=NUM_ROWS without wrap.

Reset
REQ-030 Reset SHALL force IDLE and drive rowaddr=0, busy=0, done=0, hit=0, firsthit=0, hitcount=0, and clear captured posjug/mode and accumulators.
REQ-031 Reset asserted mid-scan SHALL abort the scan with no done pulse; reset SHALL take priority over start in the same cycle.

Verification
REQ-032 Reset for 2 cycles, then release -> all outputs 0, FSM in IDLE, busy=0.
REQ-033 Mode 0, posjug=8'hA0, row3=8'h5F, other rows 8'hA0, pulse start -> done 10 cycles later, hit=1, firsthit=3, hitcount=1.
REQ-034 Mode 1, posjug=8'h30, row1=8'h10, row6=8'h20, other rows 8'h0F -> hit=1, firsthit=1, hitcount=2.
REQ-035 Mode 1, posjug=8'hF0, all rows 8'h0F -> hit=0, firsthit=0, hitcount=0, done still pulses once.
REQ-036 Start re-pulsed at cycle 3 of a scan, with posjug changed at the same time -> single done, results per the original capture, second start ignored.
REQ-037 Reset at cycle 4 of a scan whose prior result was hit=1 -> busy=0 and outputs 0 on the next cycle, no done; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/cc_poscomparator_scan_if.sv
// Request/board-memory/result bundle for the position comparator scanner.
// master = requester plus board memory, slave = scanner.
interface cc_poscomparator_scan_if #(
  parameter int PosCOMPARATOR_DATAWIDTH = 8,
  parameter int ROWIDX_WIDTH            = 3
);
  logic                               CC_POSCOMPARATOR_SCAN_start;
  logic                               CC_POSCOMPARATOR_SCAN_mode;
  logic [PosCOMPARATOR_DATAWIDTH-1:0] CC_POSCOMPARATOR_SCAN_posjug;
  logic [ROWIDX_WIDTH-1:0]            CC_POSCOMPARATOR_SCAN_rowaddr;
  logic [PosCOMPARATOR_DATAWIDTH-1:0] CC_POSCOMPARATOR_SCAN_rowdata;
  logic                               CC_POSCOMPARATOR_SCAN_busy;
  logic                               CC_POSCOMPARATOR_SCAN_done;
  logic                               CC_POSCOMPARATOR_SCAN_hit;
  logic [ROWIDX_WIDTH-1:0]            CC_POSCOMPARATOR_SCAN_firsthit;
  logic [ROWIDX_WIDTH:0]              CC_POSCOMPARATOR_SCAN_hitcount;

  modport master (
    output CC_POSCOMPARATOR_SCAN_start, CC_POSCOMPARATOR_SCAN_mode,
           CC_POSCOMPARATOR_SCAN_posjug, CC_POSCOMPARATOR_SCAN_rowdata,
    input  CC_POSCOMPARATOR_SCAN_rowaddr, CC_POSCOMPARATOR_SCAN_busy,
           CC_POSCOMPARATOR_SCAN_done, CC_POSCOMPARATOR_SCAN_hit,
           CC_POSCOMPARATOR_SCAN_firsthit, CC_POSCOMPARATOR_SCAN_hitcount
  );

  modport slave (
    input  CC_POSCOMPARATOR_SCAN_start, CC_POSCOMPARATOR_SCAN_mode,
           CC_POSCOMPARATOR_SCAN_posjug, CC_POSCOMPARATOR_SCAN_rowdata,
    output CC_POSCOMPARATOR_SCAN_rowaddr, CC_POSCOMPARATOR_SCAN_busy,
           CC_POSCOMPARATOR_SCAN_done, CC_POSCOMPARATOR_SCAN_hit,
           CC_POSCOMPARATOR_SCAN_firsthit, CC_POSCOMPARATOR_SCAN_hitcount
  );
endinterface

// File: rtl/cc_poscomparator_scan.sv
// Scans NUM_ROWS board rows from a synchronous-read memory and compares a bit
// field of each row against the captured player position (complement or overlap).
module cc_poscomparator_scan #(
  parameter int PosCOMPARATOR_DATAWIDTH = 8,
  parameter int FIELD_LSB               = 4,
  parameter int FIELD_WIDTH             = 4,
  parameter int NUM_ROWS                = 8,
  parameter int ROWIDX_WIDTH            = 3
) (
  input logic                     CC_POSCOMPARATOR_SCAN_CLOCK_50,
  input logic                     CC_POSCOMPARATOR_SCAN_RESET_InHigh,
  cc_poscomparator_scan_if.slave  scanBus
);

  localparam int DW    = PosCOMPARATOR_DATAWIDTH;
  localparam int FMSB  = FIELD_LSB + FIELD_WIDTH - 1;
  localparam int CNT_W = ROWIDX_WIDTH + 1;
  localparam logic [ROWIDX_WIDTH-1:0] LAST_ROW = ROWIDX_WIDTH'(NUM_ROWS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  generate
    if (FIELD_LSB + FIELD_WIDTH > DW || FIELD_WIDTH < 1 ||
        NUM_ROWS < 1 || NUM_ROWS > (1 << ROWIDX_WIDTH)) begin : gParamCheck
      $error("cc_poscomparator_scan: illegal parameter combination");
    end
  endgenerate

  logic                    clk;
  logic                    rst;
  logic [1:0]              state;
  logic [DW-1:0]           posCap;
  logic                    modeCap;
  logic [ROWIDX_WIDTH-1:0] rowAddr;
  logic [ROWIDX_WIDTH-1:0] rowIdx_p1;
  logic                    vld_p1;
  logic                    accFound;
  logic [ROWIDX_WIDTH-1:0] accFirst;
  logic [CNT_W-1:0]        accCount;
  logic                    busyR;
  logic                    doneR;
  logic                    hitR;
  logic [ROWIDX_WIDTH-1:0] firstR;
  logic [CNT_W-1:0]        countR;

  logic                    rowMatch;
  logic                    nxtFound;
  logic [ROWIDX_WIDTH-1:0] nxtFirst;
  logic [CNT_W-1:0]        nxtCount;

  assign clk = CC_POSCOMPARATOR_SCAN_CLOCK_50;
  assign rst = CC_POSCOMPARATOR_SCAN_RESET_InHigh;

  function automatic logic fieldMatch(input logic [DW-1:0] row,
                                      input logic [DW-1:0] pos,
                                      input logic          overlap);
    logic [FIELD_WIDTH-1:0] fRow;
    logic [FIELD_WIDTH-1:0] fPos;
    fRow = row[FMSB:FIELD_LSB];
    fPos = pos[FMSB:FIELD_LSB];
    if (overlap) return |(fRow & fPos);
    else         return fRow == ~fPos;
  endfunction

  // Compare stage: rowdata now belongs to the address registered last cycle.
  always_comb begin
    rowMatch = vld_p1 && fieldMatch(scanBus.CC_POSCOMPARATOR_SCAN_rowdata, posCap, modeCap);
    nxtFound = accFound;
    nxtFirst = accFirst;
    nxtCount = accCount;
    if (rowMatch) begin
      nxtCount = accCount + CNT_W'(1);
      if (!accFound) begin
        nxtFound = 1'b1;
        nxtFirst = rowIdx_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      posCap    <= '0;
      modeCap   <= 1'b0;
      rowAddr   <= '0;
      rowIdx_p1 <= '0;
      vld_p1    <= 1'b0;
      accFound  <= 1'b0;
      accFirst  <= '0;
      accCount  <= '0;
      busyR     <= 1'b0;
      doneR     <= 1'b0;
      hitR      <= 1'b0;
      firstR    <= '0;
      countR    <= '0;
    end else begin
      rowIdx_p1 <= rowAddr;
      vld_p1    <= (state == SCAN);
      accFound  <= nxtFound;
      accFirst  <= nxtFirst;
      accCount  <= nxtCount;
      case (state)
        IDLE: begin
          rowAddr <= '0;
          if (scanBus.CC_POSCOMPARATOR_SCAN_start) begin
            posCap   <= scanBus.CC_POSCOMPARATOR_SCAN_posjug;
            modeCap  <= scanBus.CC_POSCOMPARATOR_SCAN_mode;
            accFound <= 1'b0;
            accFirst <= '0;
            accCount <= '0;
            busyR    <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (rowAddr == LAST_ROW) begin
            rowAddr <= '0;
            state   <= DRAIN;
          end else begin
            rowAddr <= rowAddr + ROWIDX_WIDTH'(1);
          end
        end
        DRAIN: begin
          // The last row's compare lands this cycle, so publish the next-state sums.
          busyR  <= 1'b0;
          doneR  <= 1'b1;
          hitR   <= nxtFound;
          firstR <= nxtFirst;
          countR <= nxtCount;
          state  <= DONE;
        end
        default: begin
          doneR   <= 1'b0;
          rowAddr <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign scanBus.CC_POSCOMPARATOR_SCAN_rowaddr  = rowAddr;
  assign scanBus.CC_POSCOMPARATOR_SCAN_busy     = busyR;
  assign scanBus.CC_POSCOMPARATOR_SCAN_done     = doneR;
  assign scanBus.CC_POSCOMPARATOR_SCAN_hit      = hitR;
  assign scanBus.CC_POSCOMPARATOR_SCAN_firsthit = firstR;
  assign scanBus.CC_POSCOMPARATOR_SCAN_hitcount = countR;

endmodule

// File: tb/tb_cc_poscomparator_scan.sv
// Self-checking bench for cc_poscomparator_scan: board memory model plus a
// row-by-row reference of the match rules, driven by directed and random scans.
module tb_cc_poscomparator_scan;
  localparam int N   = 8;
  localparam int WIN = 2 * N + 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem [N];
  int         doneAt;
  int         doneCount;
  logic [2:0] addrSeen [WIN+1];
  logic       busySeen [WIN+1];

  cc_poscomparator_scan_if #(.PosCOMPARATOR_DATAWIDTH(8), .ROWIDX_WIDTH(3)) sif ();

  cc_poscomparator_scan #(
    .PosCOMPARATOR_DATAWIDTH(8), .FIELD_LSB(4), .FIELD_WIDTH(4),
    .NUM_ROWS(N), .ROWIDX_WIDTH(3)
  ) dut (
    .CC_POSCOMPARATOR_SCAN_CLOCK_50    (clk),
    .CC_POSCOMPARATOR_SCAN_RESET_InHigh(rst),
    .scanBus                           (sif.slave)
  );

  always #5 clk = ~clk;

  // Synchronous-read board memory: data appears one cycle after the address.
  always @(posedge clk) sif.CC_POSCOMPARATOR_SCAN_rowdata <= mem[sif.CC_POSCOMPARATOR_SCAN_rowaddr];

  // Reference: walk every row with integer arithmetic on the upper nibble.
  task automatic model(input logic [7:0] pos, input logic m,
                       output logic eHit, output logic [2:0] eFirst, output logic [3:0] eCount);
    int cnt;
    int first;
    int pf;
    int rf;
    bit match;
    cnt = 0; first = -1; pf = (pos >> 4) & 15;
    for (int i = 0; i < N; i++) begin
      rf = (mem[i] >> 4) & 15;
      match = m ? ((rf & pf) != 0) : (rf == 15 - pf);
      if (match) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    eHit   = (cnt != 0);
    eFirst = (first < 0) ? 3'd0 : 3'(first);
    eCount = 4'(cnt);
  endtask

  // Pulses start and records done/busy/rowaddr at each falling edge after the
  // sampling edge; optionally re-pulses start with altered inputs at cycle repulseAt.
  task automatic do_scan(input logic [7:0] pos, input logic m, input int repulseAt);
    @(negedge clk);
    sif.CC_POSCOMPARATOR_SCAN_start  = 1'b1;
    sif.CC_POSCOMPARATOR_SCAN_posjug = pos;
    sif.CC_POSCOMPARATOR_SCAN_mode   = m;
    @(negedge clk);
    sif.CC_POSCOMPARATOR_SCAN_start = 1'b0;
    doneAt = 0; doneCount = 0;
    for (int k = 1; k <= WIN; k++) begin
      addrSeen[k] = sif.CC_POSCOMPARATOR_SCAN_rowaddr;
      busySeen[k] = sif.CC_POSCOMPARATOR_SCAN_busy;
      if (sif.CC_POSCOMPARATOR_SCAN_done) begin
        doneCount++;
        if (doneAt == 0) doneAt = k;
      end
      if (k == repulseAt) begin
        sif.CC_POSCOMPARATOR_SCAN_start  = 1'b1;
        sif.CC_POSCOMPARATOR_SCAN_posjug = ~pos;
        sif.CC_POSCOMPARATOR_SCAN_mode   = ~m;
      end
      if (k == repulseAt + 1) sif.CC_POSCOMPARATOR_SCAN_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total += 6;
    if (sif.CC_POSCOMPARATOR_SCAN_rowaddr !== 3'd0) begin bad++; $display("FAIL reset_rowaddr got=%0d want=0", sif.CC_POSCOMPARATOR_SCAN_rowaddr); end
    if (sif.CC_POSCOMPARATOR_SCAN_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", sif.CC_POSCOMPARATOR_SCAN_busy); end
    if (sif.CC_POSCOMPARATOR_SCAN_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", sif.CC_POSCOMPARATOR_SCAN_done); end
    if (sif.CC_POSCOMPARATOR_SCAN_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b want=0", sif.CC_POSCOMPARATOR_SCAN_hit); end
    if (sif.CC_POSCOMPARATOR_SCAN_firsthit !== 3'd0) begin bad++; $display("FAIL reset_firsthit got=%0d want=0", sif.CC_POSCOMPARATOR_SCAN_firsthit); end
    if (sif.CC_POSCOMPARATOR_SCAN_hitcount !== 4'd0) begin bad++; $display("FAIL reset_hitcount got=%0d want=0", sif.CC_POSCOMPARATOR_SCAN_hitcount); end
  endtask

  // Shared scenario body: each caller loads mem first; result checks are inline.
  task automatic test_scan(input string name, input logic [7:0] pos, input logic m,
                           input int repulseAt, input bit checkTiming);
    logic eHit; logic [2:0] eFirst; logic [3:0] eCount;
    model(pos, m, eHit, eFirst, eCount);
    do_scan(pos, m, repulseAt);
    total += 5;
    if (doneAt !== N + 2) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, doneAt, N + 2); end
    if (doneCount !== 1) begin bad++; $display("FAIL %s_donecount got=%0d want=1", name, doneCount); end
    if (sif.CC_POSCOMPARATOR_SCAN_hit !== eHit) begin bad++; $display("FAIL %s_hit got=%0b want=%0b", name, sif.CC_POSCOMPARATOR_SCAN_hit, eHit); end
    if (sif.CC_POSCOMPARATOR_SCAN_firsthit !== eFirst) begin bad++; $display("FAIL %s_firsthit got=%0d want=%0d", name, sif.CC_POSCOMPARATOR_SCAN_firsthit, eFirst); end
    if (sif.CC_POSCOMPARATOR_SCAN_hitcount !== eCount) begin bad++; $display("FAIL %s_hitcount got=%0d want=%0d", name, sif.CC_POSCOMPARATOR_SCAN_hitcount, eCount); end
    if (checkTiming) begin
      for (int k = 1; k <= N + 2; k++) begin
        total++;
        if (k <= N && addrSeen[k] !== 3'(k - 1)) begin bad++; $display("FAIL %s_rowaddr cyc=%0d got=%0d want=%0d", name, k, addrSeen[k], k - 1); end
        else if (busySeen[k] !== (k <= N + 1)) begin bad++; $display("FAIL %s_busy cyc=%0d got=%0b want=%0b", name, k, busySeen[k], k <= N + 1); end
      end
    end
  endtask

  task automatic test_complement();
    for (int i = 0; i < N; i++) mem[i] = 8'hA0;
    mem[3] = 8'h5F;
    test_scan("complement", 8'hA0, 1'b0, 0, 1'b1);
    total += 3;
    if (sif.CC_POSCOMPARATOR_SCAN_hit !== 1'b1) begin bad++; $display("FAIL complement_hit_const got=%0b want=1", sif.CC_POSCOMPARATOR_SCAN_hit); end
    if (sif.CC_POSCOMPARATOR_SCAN_firsthit !== 3'd3) begin bad++; $display("FAIL complement_first_const got=%0d want=3", sif.CC_POSCOMPARATOR_SCAN_firsthit); end
    if (sif.CC_POSCOMPARATOR_SCAN_hitcount !== 4'd1) begin bad++; $display("FAIL complement_count_const got=%0d want=1", sif.CC_POSCOMPARATOR_SCAN_hitcount); end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < N; i++) mem[i] = 8'h0F;
    mem[1] = 8'h10; mem[6] = 8'h20;
    test_scan("overlap", 8'h30, 1'b1, 0, 1'b0);
    total += 2;
    if (sif.CC_POSCOMPARATOR_SCAN_firsthit !== 3'd1) begin bad++; $display("FAIL overlap_first_const got=%0d want=1", sif.CC_POSCOMPARATOR_SCAN_firsthit); end
    if (sif.CC_POSCOMPARATOR_SCAN_hitcount !== 4'd2) begin bad++; $display("FAIL overlap_count_const got=%0d want=2", sif.CC_POSCOMPARATOR_SCAN_hitcount); end
  endtask

  task automatic test_nomatch();
    for (int i = 0; i < N; i++) mem[i] = 8'h0F;
    test_scan("nomatch", 8'hF0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_allmatch();
    for (int i = 0; i < N; i++) mem[i] = 8'(8'h10 * (i + 1) + i);
    test_scan("allmatch", 8'hF3, 1'b1, 0, 1'b0);
    total++;
    if (sif.CC_POSCOMPARATOR_SCAN_hitcount !== 4'd8) begin bad++; $display("FAIL allmatch_count_const got=%0d want=8", sif.CC_POSCOMPARATOR_SCAN_hitcount); end
  endtask

  task automatic test_random();
    logic [7:0] pos;
    logic m;
    for (int it = 0; it < 20; it++) begin
      pos = 8'($urandom);
      m   = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        mem[i] = 8'($urandom);
        if ($urandom_range(3) == 0) mem[i][7:4] = ~pos[7:4];
      end
      test_scan("random", pos, m, 0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) mem[i] = 8'h0F;
    mem[5] = 8'hC0;
    // The re-pulse carries inverted pos/mode; the result must follow the original capture.
    test_scan("ignore_start", 8'h80, 1'b1, 3, 1'b0);
    total++;
    if (sif.CC_POSCOMPARATOR_SCAN_firsthit !== 3'd5) begin bad++; $display("FAIL ignore_start_first_const got=%0d want=5", sif.CC_POSCOMPARATOR_SCAN_firsthit); end
  endtask

  task automatic test_reset_midscan();
    int seenDone;
    for (int i = 0; i < N; i++) mem[i] = 8'h0F;
    mem[2] = 8'hF0;
    test_scan("prior", 8'h0F, 1'b0, 0, 1'b0);
    @(negedge clk);
    sif.CC_POSCOMPARATOR_SCAN_start = 1'b1;
    @(negedge clk);
    sif.CC_POSCOMPARATOR_SCAN_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total += 5;
    if (sif.CC_POSCOMPARATOR_SCAN_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", sif.CC_POSCOMPARATOR_SCAN_busy); end
    if (sif.CC_POSCOMPARATOR_SCAN_hit !== 1'b0) begin bad++; $display("FAIL midrst_hit got=%0b want=0", sif.CC_POSCOMPARATOR_SCAN_hit); end
    if (sif.CC_POSCOMPARATOR_SCAN_firsthit !== 3'd0) begin bad++; $display("FAIL midrst_firsthit got=%0d want=0", sif.CC_POSCOMPARATOR_SCAN_firsthit); end
    if (sif.CC_POSCOMPARATOR_SCAN_hitcount !== 4'd0) begin bad++; $display("FAIL midrst_hitcount got=%0d want=0", sif.CC_POSCOMPARATOR_SCAN_hitcount); end
    if (sif.CC_POSCOMPARATOR_SCAN_rowaddr !== 3'd0) begin bad++; $display("FAIL midrst_rowaddr got=%0d want=0", sif.CC_POSCOMPARATOR_SCAN_rowaddr); end
    // Reset wins over a start presented in the same cycle.
    sif.CC_POSCOMPARATOR_SCAN_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sif.CC_POSCOMPARATOR_SCAN_start = 1'b0;
    total++;
    if (sif.CC_POSCOMPARATOR_SCAN_busy !== 1'b0) begin bad++; $display("FAIL rst_priority_busy got=%0b want=0", sif.CC_POSCOMPARATOR_SCAN_busy); end
    seenDone = 0;
    for (int k = 0; k < 2 * N; k++) begin
      if (sif.CC_POSCOMPARATOR_SCAN_done) seenDone++;
      @(negedge clk);
    end
    total++;
    if (seenDone !== 0) begin bad++; $display("FAIL midrst_nodone got=%0d want=0", seenDone); end
    test_scan("after_rst", 8'h0F, 1'b0, 0, 1'b1);
  endtask

  initial begin
    sif.CC_POSCOMPARATOR_SCAN_start  = 1'b0;
    sif.CC_POSCOMPARATOR_SCAN_mode   = 1'b0;
    sif.CC_POSCOMPARATOR_SCAN_posjug = 8'h00;
    for (int i = 0; i < N; i++) mem[i] = 8'h00;
    test_reset();
    test_complement();
    test_overlap();
    test_nomatch();
    test_allmatch();
    test_random();
    test_back_to_back();
    test_reset_midscan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
